// File: rtl/key_scan_matrix.sv
// key_scan_matrix
//   Parametrised matrix-keypad scanner. Strobes one row at a time and samples
//   the synchronised column returns into a frame image. Presses and releases
//   are debounced over whole frames, and each accepted press is reported
//   once as a key code.
//
//   Optional feature macro: KEY_SCAN_RELEASE_EVT_EN
//     When defined, a key_rel port is added. It pulses for one cycle when a
//     debounced release is accepted.
//
// Ports:
//   clk        in   single clock
//   rst        in   asynchronous active-high reset
//   row        out  [ROWS]  one-hot row drive, active-high
//   key_col    in   [COLS]  raw column returns, asynchronous to clk
//   key_code   out  [KW]    {row_idx, col_idx} of the last accepted press
//   key_valid  out          one-cycle pulse on an accepted press
//   key_down   out          high while the accepted key is held
//   key_rel    out          one-cycle pulse on an accepted release (macro only)
//   key_multi  out          more than one key seen in the last completed frame
//
// FSM states:
//   state     | meaning
//   IDLE      | no key accepted, waiting for a candidate
//   PRESS_DEB | candidate stable for deb_cnt frames, not yet accepted
//   HELD      | key accepted and still present
//   REL_DEB   | accepted key absent for deb_cnt frames
module key_scan_matrix #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1_000_000,
  parameter int DEB_FRAMES = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic [ROWS-1:0]                      row,
  input  logic [COLS-1:0]                      key_col,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0] key_code,
  output logic                                 key_valid,
  output logic                                 key_down,
`ifdef KEY_SCAN_RELEASE_EVT_EN
  output logic                                 key_rel,
`endif
  output logic                                 key_multi
);

  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int KW   = RW + CW;
  localparam int NK   = ROWS * COLS;
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int DW   = $clog2(DEB_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } state_t;

  // Scan timing and frame capture
  logic [COLS-1:0]    col_s1, col_s2;
  logic [DIVW-1:0]    div_cnt;
  logic [RW-1:0]      row_idx;
  logic [NK-COLS-1:0] frame_acc;
  logic [NK-1:0]      frame_img;
  logic               frame_done;
  logic               slot_end;
  logic               last_row;

  assign slot_end = (div_cnt == DIVW'(SCAN_DIV - 1));
  assign last_row = (row_idx == RW'(ROWS - 1));
  assign row      = ROWS'(1) << row_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1     <= '0;
      col_s2     <= '0;
      div_cnt    <= '0;
      row_idx    <= '0;
      frame_acc  <= '0;
      frame_img  <= '0;
      frame_done <= 1'b0;
    end else begin
      col_s1     <= key_col;
      col_s2     <= col_s1;
      frame_done <= slot_end && last_row;
      if (slot_end) begin
        div_cnt <= '0;
        row_idx <= last_row ? '0 : row_idx + 1'b1;
        // The last row goes straight into the image so the whole frame is
        // available to the FSM on the cycle after completion.
        if (last_row) begin
          frame_img <= {col_s2, frame_acc};
        end else begin
          frame_acc[row_idx*COLS +: COLS] <= col_s2;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Candidate (lowest pressed index, row-major) and popcount
  logic          cand_vld;
  logic [KW-1:0] cand_idx;
  logic [KW:0]   pop_cnt;

  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    pop_cnt  = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (frame_img[i]) begin
        cand_vld = 1'b1;
        cand_idx = KW'(i);
      end
      pop_cnt = pop_cnt + {{KW{1'b0}}, frame_img[i]};
    end
  end

  // Debounce FSM
  state_t        state, state_n;
  logic [KW-1:0] held_key, held_n;
  logic [DW-1:0] deb_cnt, deb_n, deb_inc;
  logic [KW-1:0] code_n;
  logic          valid_n, down_n, multi_n;
`ifdef KEY_SCAN_RELEASE_EVT_EN
  logic          rel_n;
`endif

  assign deb_inc = (deb_cnt == DW'(DEB_FRAMES)) ? deb_cnt : deb_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      held_key  <= '0;
      deb_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      key_multi <= 1'b0;
`ifdef KEY_SCAN_RELEASE_EVT_EN
      key_rel   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      held_key  <= held_n;
      deb_cnt   <= deb_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_down  <= down_n;
      key_multi <= multi_n;
`ifdef KEY_SCAN_RELEASE_EVT_EN
      key_rel   <= rel_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    held_n  = held_key;
    deb_n   = deb_cnt;
    code_n  = key_code;
    valid_n = 1'b0;
    down_n  = key_down;
    multi_n = key_multi;
`ifdef KEY_SCAN_RELEASE_EVT_EN
    rel_n   = 1'b0;
`endif
    if (frame_done) begin
      multi_n = (pop_cnt > (KW+1)'(1));
      case (state)
        IDLE: begin
          if (cand_vld) begin
            held_n = cand_idx;
            deb_n  = DW'(1);
            if (DEB_FRAMES == 1) begin
              state_n = HELD;
              code_n  = cand_idx;
              valid_n = 1'b1;
              down_n  = 1'b1;
            end else begin
              state_n = PRESS_DEB;
            end
          end
        end
        PRESS_DEB: begin
          if (!cand_vld) begin
            state_n = IDLE;
            deb_n   = '0;
          end else if (cand_idx == held_key) begin
            deb_n = deb_inc;
            if (deb_inc == DW'(DEB_FRAMES)) begin
              state_n = HELD;
              code_n  = held_key;
              valid_n = 1'b1;
              down_n  = 1'b1;
            end
          end else begin
            held_n = cand_idx;
            deb_n  = DW'(1);
          end
        end
        HELD: begin
          // Only the accepted key matters here; other keys are ignored.
          if (!frame_img[held_key]) begin
            deb_n = DW'(1);
            if (DEB_FRAMES == 1) begin
              state_n = IDLE;
              down_n  = 1'b0;
`ifdef KEY_SCAN_RELEASE_EVT_EN
              rel_n   = 1'b1;
`endif
            end else begin
              state_n = REL_DEB;
            end
          end
        end
        REL_DEB: begin
          if (frame_img[held_key]) begin
            state_n = HELD;
            deb_n   = '0;
          end else begin
            deb_n = deb_inc;
            if (deb_inc == DW'(DEB_FRAMES)) begin
              state_n = IDLE;
              down_n  = 1'b0;
`ifdef KEY_SCAN_RELEASE_EVT_EN
              rel_n   = 1'b1;
`endif
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan_matrix.sv
// Testbench for key_scan_matrix with ROWS = COLS = 4, SCAN_DIV = 8,
// DEB_FRAMES = 3 (one frame = 32 cycles). Key bit r*4+c of 'pressed' models
// key (r,c); the keypad returns key_col[c] = row[r] & pressed[r][c].
module tb_key_scan_matrix;

  localparam int FRAME = 32;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       key_multi;
`ifdef KEY_SCAN_RELEASE_EVT_EN
  logic       key_rel;
`endif

  logic [15:0] pressed;

  int n_checks;
  int n_err;

  key_scan_matrix #(
    .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEB_FRAMES(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down),
`ifdef KEY_SCAN_RELEASE_EVT_EN
    .key_rel  (key_rel),
`endif
    .key_multi(key_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    key_col = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row[r] && pressed[r*4+c]) key_col[c] = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Each phase holds a key pattern for a number of frames. Phases start one
  // cycle after a frame boundary so each frame's FSM update falls inside the
  // phase. first_* are phase-local cycle numbers (32 * frame within phase).
  typedef struct {
    logic [15:0] pressed;
    int frames;
    int n_valid;
    int first_valid;
    int n_rel;
    int first_rel;
    int code;
    int down;
    int multi;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int nv, fv, nr, fr;
    logic prev_down;

    n_checks = 0;
    n_err    = 0;
    pressed  = '0;
    rst      = 1'b1;

    //              pressed              fr nv fv  nr fr  code down multi
    vecs[0]  = '{16'h0000,               2, 0, 0,  0, 0,  0, 0, 0};
    vecs[1]  = '{16'h0200,               6, 1, 96, 0, 0,  9, 1, 0};
    vecs[2]  = '{16'h0000,               1, 0, 0,  0, 0,  9, 1, 0};
    vecs[3]  = '{16'h0200,               2, 0, 0,  0, 0,  9, 1, 0};
    vecs[4]  = '{16'h0000,               3, 0, 0,  1, 96, 9, 0, 0};
    vecs[5]  = '{16'h0200,               1, 0, 0,  0, 0,  9, 0, 0};
    vecs[6]  = '{16'h0000,               1, 0, 0,  0, 0,  9, 0, 0};
    vecs[7]  = '{16'h0200,               5, 1, 96, 0, 0,  9, 1, 0};
    vecs[8]  = '{16'h0000,               3, 0, 0,  1, 96, 9, 0, 0};
    vecs[9]  = '{16'h0180,               4, 1, 96, 0, 0,  7, 1, 1};
    vecs[10] = '{16'h0080,               1, 0, 0,  0, 0,  7, 1, 0};
    vecs[11] = '{16'h0000,               3, 0, 0,  1, 96, 7, 0, 0};
    vecs[12] = '{16'h0200,               1, 0, 0,  0, 0,  7, 0, 0};
    vecs[13] = '{16'h0004,               3, 1, 96, 0, 0,  2, 1, 0};
    vecs[14] = '{16'h0000,               3, 0, 0,  1, 96, 2, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset_row", int'(row), 1);
    chk("reset_outputs", int'({key_code, key_valid, key_down, key_multi}), 0);
    rst = 1'b0;

    // Free run with no keys: rows 1,2,4,8 each for 8 cycles.
    for (int k = 0; k < 33; k++) begin
      if (k < FRAME) begin
        chk($sformatf("free_row[%0d]", k), int'(row), 1 << ((k / 8) % 4));
        chk($sformatf("free_outputs[%0d]", k),
            int'({key_code, key_valid, key_down, key_multi}), 0);
      end
      @(negedge clk);
    end

    prev_down = key_down;
    for (int i = 0; i < 15; i++) begin
      pressed = vecs[i].pressed;
      nv = 0; fv = 0; nr = 0; fr = 0;
      for (int c = 1; c <= vecs[i].frames * FRAME; c++) begin
        @(negedge clk);
        if (key_valid) begin
          nv++;
          if (fv == 0) fv = c;
        end
`ifdef KEY_SCAN_RELEASE_EVT_EN
        if (key_rel) begin
          nr++;
          if (fr == 0) fr = c;
          chk($sformatf("v%0d_rel_down_same_cycle", i),
              int'({prev_down, key_down}), 2);
        end
`endif
        prev_down = key_down;
      end
      chk($sformatf("v%0d_valid_count", i), nv, vecs[i].n_valid);
      chk($sformatf("v%0d_valid_cycle", i), fv, vecs[i].first_valid);
      chk($sformatf("v%0d_code", i), int'(key_code), vecs[i].code);
      chk($sformatf("v%0d_down", i), int'(key_down), vecs[i].down);
      chk($sformatf("v%0d_multi", i), int'(key_multi), vecs[i].multi);
`ifdef KEY_SCAN_RELEASE_EVT_EN
      chk($sformatf("v%0d_rel_count", i), nr, vecs[i].n_rel);
      chk($sformatf("v%0d_rel_cycle", i), fr, vecs[i].first_rel);
`endif
    end

    // Reset in PRESS_DEB with key_multi set, asserted mid-cycle.
    pressed = 16'h0180;
    repeat (2 * FRAME + 5) @(negedge clk);
    chk("pre_rst_multi", int'(key_multi), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_row", int'(row), 1);
    chk("mid_rst_code", int'(key_code), 0);
    chk("mid_rst_flags", int'({key_valid, key_down, key_multi}), 0);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    pressed = 16'h0200;
    chk("post_rst_row", int'(row), 1);
    nv = 0; fv = 0;
    for (int c = 1; c <= 3 * FRAME + 4; c++) begin
      @(negedge clk);
      if (key_valid) begin
        nv++;
        if (fv == 0) fv = c;
      end
    end
    chk("post_rst_valid_count", nv, 1);
    chk("post_rst_valid_cycle", fv, 3 * FRAME + 1);
    chk("post_rst_code", int'(key_code), 9);
    chk("post_rst_down", int'(key_down), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
